// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller: hex decode, leading-zero blanking,
// per-digit decimal points and frame-synchronised double-buffered digit data.

module seg7_scan_ctrl_chk #(
  parameter int NUM_DIGITS     = 8,
  parameter int SCAN_DIV       = 50000,
  parameter int DIV_W          = 16,
  parameter int IDX_W          = 3,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input logic                  i_clk,
  input logic                  i_rstn,
  input logic [DIV_W-1:0]      i_div_cnt,
  input logic [IDX_W-1:0]      i_idx,
  input logic [NUM_DIGITS-1:0] i_sel,
  input logic                  i_frame
);
  localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_OFF  = {NUM_DIGITS{SEL_ACTIVE_LOW}};

  a_div_range: assert property (@(posedge i_clk) disable iff (!i_rstn)
    i_div_cnt <= DIV_LAST);

  a_idx_range: assert property (@(posedge i_clk) disable iff (!i_rstn)
    i_idx <= IDX_LAST);

  // The strobe is only ever seen at the very start of a frame.
  a_frame_start: assert property (@(posedge i_clk) disable iff (!i_rstn)
    i_frame |-> (i_idx == {IDX_W{1'b0}}) && (i_div_cnt == {DIV_W{1'b0}}));

  a_sel_onehot: assert property (@(posedge i_clk) disable iff (!i_rstn)
    $onehot0(i_sel ^ SEL_OFF));
endmodule

module seg7_scan_ctrl #(
  parameter int NUM_DIGITS     = 8,
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [4*NUM_DIGITS-1:0] data_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    load_i,
  input  logic                    blank_lz_i,
  input  logic                    en_i,
  output logic [NUM_DIGITS-1:0]   tube_sel_o,
  output logic [7:0]              tube_char_o,
  output logic                    frame_o
);
  localparam int DW    = 4 * NUM_DIGITS;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0]      DIV_ONE  = DIV_W'(1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0]      IDX_ONE  = IDX_W'(1);
  localparam logic [NUM_DIGITS-1:0] SEL_OFF  = {NUM_DIGITS{SEL_ACTIVE_LOW}};
  localparam logic [7:0]            SEG_OFF  = {8{SEG_ACTIVE_LOW}};

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      4'hF:    seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  logic [DIV_W-1:0]      r_div_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [DW-1:0]         r_shown_data;
  logic [NUM_DIGITS-1:0] r_shown_dp;
  logic [DW-1:0]         r_pend_data;
  logic [NUM_DIGITS-1:0] r_pend_dp;
  logic                  r_pend_vld;
  logic [NUM_DIGITS-1:0] r_sel;
  logic [7:0]            r_char;
  logic                  r_frame;

  logic                  w_div_tc;
  logic                  w_wrap;
  logic                  w_zero_run;
  logic [NUM_DIGITS-1:0] w_lz;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic [3:0]            w_cur_nib;
  logic                  w_cur_dp;
  logic                  w_cur_lz;
  logic                  w_blank;
  logic [6:0]            w_seg;
  logic [NUM_DIGITS-1:0] w_sel_nxt;
  logic [7:0]            w_char_nxt;

  assign w_div_tc = (r_div_cnt == DIV_LAST);
  assign w_wrap   = w_div_tc && (r_idx == IDX_LAST);

  // Scan timing: per-digit dwell counter and digit index.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_div_cnt <= {DIV_W{1'b0}};
      r_idx     <= {IDX_W{1'b0}};
    end else if (w_div_tc) begin
      r_div_cnt <= {DIV_W{1'b0}};
      r_idx     <= w_wrap ? {IDX_W{1'b0}} : (r_idx + IDX_ONE);
    end else begin
      r_div_cnt <= r_div_cnt + DIV_ONE;
    end
  end

  // Double buffer: a load in the wrap cycle bypasses the pending stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_shown_data <= {DW{1'b0}};
      r_shown_dp   <= {NUM_DIGITS{1'b0}};
      r_pend_data  <= {DW{1'b0}};
      r_pend_dp    <= {NUM_DIGITS{1'b0}};
      r_pend_vld   <= 1'b0;
    end else if (w_wrap) begin
      if (load_i) begin
        r_shown_data <= data_i;
        r_shown_dp   <= dp_i;
      end else if (r_pend_vld) begin
        r_shown_data <= r_pend_data;
        r_shown_dp   <= r_pend_dp;
      end
      r_pend_vld <= 1'b0;
    end else if (load_i) begin
      r_pend_data <= data_i;
      r_pend_dp   <= dp_i;
      r_pend_vld  <= 1'b1;
    end
  end

  // Leading-zero map and AND-OR selection of the current digit's fields.
  always_comb begin
    w_zero_run = 1'b1;
    w_lz       = {NUM_DIGITS{1'b0}};
    w_onehot   = {NUM_DIGITS{1'b0}};
    w_cur_nib  = 4'h0;
    w_cur_dp   = 1'b0;
    w_cur_lz   = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_zero_run = w_zero_run & (r_shown_data[4*k +: 4] == 4'h0);
      w_lz[k]    = w_zero_run;
    end
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_onehot[k] = (r_idx == IDX_W'(k));
      w_cur_nib   = w_cur_nib | (r_shown_data[4*k +: 4] & {4{w_onehot[k]}});
      w_cur_dp    = w_cur_dp | (r_shown_dp[k] & w_onehot[k]);
      w_cur_lz    = w_cur_lz | (w_lz[k] & w_onehot[k]);
    end
  end

  // Glyph, blanking, polarity and enable gating for the next output word.
  always_comb begin
    w_blank    = blank_lz_i & w_cur_lz & (r_idx != {IDX_W{1'b0}});
    w_seg      = w_blank ? 7'h00 : hex_to_seg(w_cur_nib);
    w_char_nxt = {w_cur_dp, w_seg} ^ SEG_OFF;
    if (en_i) begin
      w_sel_nxt = w_onehot ^ SEL_OFF;
    end else begin
      w_sel_nxt = SEL_OFF;
    end
  end

  // Output registers; these lag the digit index by one clock.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sel   <= SEL_OFF;
      r_char  <= SEG_OFF;
      r_frame <= 1'b0;
    end else begin
      r_sel   <= w_sel_nxt;
      r_char  <= w_char_nxt;
      r_frame <= w_wrap;
    end
  end

  assign tube_sel_o  = r_sel;
  assign tube_char_o = r_char;
  assign frame_o     = r_frame;

  seg7_scan_ctrl_chk #(
    .NUM_DIGITS     (NUM_DIGITS),
    .SCAN_DIV       (SCAN_DIV),
    .DIV_W          (DIV_W),
    .IDX_W          (IDX_W),
    .SEL_ACTIVE_LOW (SEL_ACTIVE_LOW)
  ) u_chk (
    .i_clk     (clk),
    .i_rstn    (rstn),
    .i_div_cnt (r_div_cnt),
    .i_idx     (r_idx),
    .i_sel     (r_sel),
    .i_frame   (r_frame)
  );
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: an 8-digit active-low instance (SCAN_DIV=4)
// and a 4-digit active-high instance (SCAN_DIV=2).

module tb_seg7_scan_ctrl;
  logic clk;
  logic rstn;

  logic [31:0] data_i;
  logic [7:0]  dp_i;
  logic        load_i;
  logic        blank_lz_i;
  logic        en_i;
  logic [7:0]  tube_sel_o;
  logic [7:0]  tube_char_o;
  logic        frame_o;

  logic [15:0] data4;
  logic [3:0]  dp4;
  logic        load4;
  logic        blank4;
  logic        en4;
  logic [3:0]  sel4;
  logic [7:0]  char4;
  logic        frame4;

  int checks;
  int failures;

  logic [7:0] cap_sel   [1:32];
  logic [7:0] cap_char  [1:32];
  logic       cap_frame [1:32];

  seg7_scan_ctrl #(
    .NUM_DIGITS(8), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rstn(rstn), .data_i(data_i), .dp_i(dp_i), .load_i(load_i),
    .blank_lz_i(blank_lz_i), .en_i(en_i), .tube_sel_o(tube_sel_o),
    .tube_char_o(tube_char_o), .frame_o(frame_o)
  );

  seg7_scan_ctrl #(
    .NUM_DIGITS(4), .SCAN_DIV(2), .SEG_ACTIVE_LOW(1'b0), .SEL_ACTIVE_LOW(1'b0)
  ) dut4 (
    .clk(clk), .rstn(rstn), .data_i(data4), .dp_i(dp4), .load_i(load4),
    .blank_lz_i(blank4), .en_i(en4), .tube_sel_o(sel4),
    .tube_char_o(char4), .frame_o(frame4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  4'hF: return 7'h71;
      default: return 7'h00;
    endcase
  endfunction

  // Expected active-low character for digit k of an 8-digit word.
  function automatic logic [7:0] exp_char(input logic [31:0] d, input logic [7:0] dp,
                                          input logic blank, input int k);
    logic       za;
    logic [6:0] seg;
    za = 1'b1;
    for (int j = 7; j >= k; j--) begin
      if (d[4*j +: 4] != 4'h0) za = 1'b0;
    end
    seg = (blank && (k > 0) && za) ? 7'h00 : glyph(d[4*k +: 4]);
    return ~{dp[k], seg};
  endfunction

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_o !== 1'b1 && n < 200);
    checks++;
    if (frame_o !== 1'b1) begin
      failures++;
      $display("FAIL frame_wait got=%b exp=1", frame_o);
    end
  endtask

  // Records 32 samples after a frame strobe, optionally pulsing load at sample load_at.
  task automatic capture_frame(input bit do_wait, input int load_at,
                               input logic [31:0] ld_data, input logic [7:0] ld_dp);
    if (do_wait) wait_frame();
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      cap_sel[i]   = tube_sel_o;
      cap_char[i]  = tube_char_o;
      cap_frame[i] = frame_o;
      if (i == load_at) begin
        data_i = ld_data;
        dp_i   = ld_dp;
        load_i = 1'b1;
      end else begin
        load_i = 1'b0;
      end
    end
    load_i = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (tube_sel_o !== 8'hFF) begin failures++; $display("FAIL reset_sel got=%h exp=ff", tube_sel_o); end
    checks++;
    if (tube_char_o !== 8'hFF) begin failures++; $display("FAIL reset_char got=%h exp=ff", tube_char_o); end
    checks++;
    if (frame_o !== 1'b0) begin failures++; $display("FAIL reset_frame got=%b exp=0", frame_o); end
    checks++;
    if (sel4 !== 4'h0) begin failures++; $display("FAIL reset_sel4 got=%h exp=0", sel4); end
    checks++;
    if (char4 !== 8'h00) begin failures++; $display("FAIL reset_char4 got=%h exp=00", char4); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] es;
    int k;
    capture_frame(1'b0, 2, 32'h12345678, 8'h00);
    for (int i = 1; i <= 32; i++) begin
      k  = (i - 1) / 4;
      es = ~(8'b1 << k);
      checks++;
      if (cap_sel[i] !== es) begin failures++; $display("FAIL first_sel[%0d] got=%h exp=%h", i, cap_sel[i], es); end
      checks++;
      if (cap_char[i] !== 8'hC0) begin failures++; $display("FAIL first_char[%0d] got=%h exp=c0", i, cap_char[i]); end
      checks++;
      if (cap_frame[i] !== (i == 32)) begin failures++; $display("FAIL first_frame[%0d] got=%b", i, cap_frame[i]); end
    end
    capture_frame(1'b0, -1, 32'h0, 8'h00);
    for (int i = 1; i <= 32; i++) begin
      k  = (i - 1) / 4;
      es = ~(8'b1 << k);
      checks++;
      if (cap_sel[i] !== es) begin failures++; $display("FAIL basic_sel[%0d] got=%h exp=%h", i, cap_sel[i], es); end
      checks++;
      if (cap_char[i] !== exp_char(32'h12345678, 8'h00, 1'b0, k)) begin
        failures++; $display("FAIL basic_char[%0d] got=%h exp=%h", i, cap_char[i], exp_char(32'h12345678, 8'h00, 1'b0, k));
      end
      checks++;
      if (cap_frame[i] !== (i == 32)) begin failures++; $display("FAIL basic_frame[%0d] got=%b", i, cap_frame[i]); end
    end
    checks++;
    if (cap_sel[1] !== 8'hFE || cap_char[1] !== ~8'h7F) begin
      failures++; $display("FAIL digit0_glyph8 got=%h/%h exp=fe/80", cap_sel[1], cap_char[1]);
    end
    checks++;
    if (cap_sel[29] !== 8'h7F || cap_char[29] !== ~8'h06) begin
      failures++; $display("FAIL digit7_glyph1 got=%h/%h exp=7f/f9", cap_sel[29], cap_char[29]);
    end
  endtask

  task automatic test_midframe_load();
    int k;
    capture_frame(1'b0, 10, 32'h0000ABCD, 8'h00);
    for (int i = 1; i <= 32; i++) begin
      k = (i - 1) / 4;
      checks++;
      if (cap_char[i] !== exp_char(32'h12345678, 8'h00, 1'b0, k)) begin
        failures++; $display("FAIL mid_old_char[%0d] got=%h exp=%h", i, cap_char[i], exp_char(32'h12345678, 8'h00, 1'b0, k));
      end
    end
    capture_frame(1'b0, -1, 32'h0, 8'h00);
    for (int i = 1; i <= 32; i++) begin
      k = (i - 1) / 4;
      checks++;
      if (cap_char[i] !== exp_char(32'h0000ABCD, 8'h00, 1'b0, k)) begin
        failures++; $display("FAIL mid_new_char[%0d] got=%h exp=%h", i, cap_char[i], exp_char(32'h0000ABCD, 8'h00, 1'b0, k));
      end
    end
    checks++;
    if (cap_char[1] !== ~8'h5E) begin failures++; $display("FAIL mid_digit0_d got=%h exp=a1", cap_char[1]); end
  endtask

  task automatic test_wrap_load();
    int k;
    capture_frame(1'b0, 31, 32'h13579BDF, 8'h00);
    for (int i = 1; i <= 32; i++) begin
      k = (i - 1) / 4;
      checks++;
      if (cap_char[i] !== exp_char(32'h0000ABCD, 8'h00, 1'b0, k)) begin
        failures++; $display("FAIL wrap_old_char[%0d] got=%h exp=%h", i, cap_char[i], exp_char(32'h0000ABCD, 8'h00, 1'b0, k));
      end
    end
    capture_frame(1'b0, -1, 32'h0, 8'h00);
    for (int i = 1; i <= 32; i++) begin
      k = (i - 1) / 4;
      checks++;
      if (cap_char[i] !== exp_char(32'h13579BDF, 8'h00, 1'b0, k)) begin
        failures++; $display("FAIL wrap_new_char[%0d] got=%h exp=%h", i, cap_char[i], exp_char(32'h13579BDF, 8'h00, 1'b0, k));
      end
    end
  endtask

  task automatic test_blanking();
    int k;
    blank_lz_i = 1'b1;
    capture_frame(1'b0, 5, 32'h000000F0, 8'h00);
    capture_frame(1'b0, -1, 32'h0, 8'h00);
    for (int i = 1; i <= 32; i++) begin
      k = (i - 1) / 4;
      checks++;
      if (cap_char[i] !== exp_char(32'h000000F0, 8'h00, 1'b1, k)) begin
        failures++; $display("FAIL blank_f0_char[%0d] got=%h exp=%h", i, cap_char[i], exp_char(32'h000000F0, 8'h00, 1'b1, k));
      end
    end
    checks++;
    if (cap_char[29] !== 8'hFF || cap_char[9] !== 8'hFF) begin
      failures++; $display("FAIL blank_upper got=%h/%h exp=ff/ff", cap_char[29], cap_char[9]);
    end
    checks++;
    if (cap_char[5] !== ~8'h71 || cap_char[1] !== ~8'h3F) begin
      failures++; $display("FAIL blank_low got=%h/%h exp=8e/c0", cap_char[5], cap_char[1]);
    end
    capture_frame(1'b0, 5, 32'h00000000, 8'h04);
    capture_frame(1'b0, -1, 32'h0, 8'h00);
    for (int i = 1; i <= 32; i++) begin
      k = (i - 1) / 4;
      checks++;
      if (cap_char[i] !== exp_char(32'h0, 8'h04, 1'b1, k)) begin
        failures++; $display("FAIL blank_zero_char[%0d] got=%h exp=%h", i, cap_char[i], exp_char(32'h0, 8'h04, 1'b1, k));
      end
    end
    checks++;
    if (cap_char[1] !== 8'hC0 || cap_char[5] !== 8'hFF || cap_char[9] !== ~8'h80) begin
      failures++; $display("FAIL blank_dp got=%h/%h/%h exp=c0/ff/7f", cap_char[1], cap_char[5], cap_char[9]);
    end
    blank_lz_i = 1'b0;
  endtask

  task automatic test_enable();
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (i >= 4 && i <= 13) begin
        checks++;
        if (tube_sel_o !== 8'hFF) begin failures++; $display("FAIL en_off_sel[%0d] got=%h exp=ff", i, tube_sel_o); end
      end
      if (i == 14) begin
        checks++;
        if (tube_sel_o !== 8'hF7) begin failures++; $display("FAIL en_resume_sel got=%h exp=f7", tube_sel_o); end
      end
      checks++;
      if (frame_o !== (i == 32)) begin failures++; $display("FAIL en_frame[%0d] got=%b", i, frame_o); end
      if (i == 3) en_i = 1'b0;
      if (i == 13) en_i = 1'b1;
    end
  endtask

  task automatic test_four_digit();
    int n;
    logic [3:0] es;
    data4 = 16'h1111;
    load4 = 1'b1;
    @(negedge clk);
    load4 = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame4 !== 1'b1 && n < 100);
    checks++;
    if (frame4 !== 1'b1) begin failures++; $display("FAIL dut4_frame_wait got=%b exp=1", frame4); end
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      es = 4'b0001 << ((i - 1) / 2);
      checks++;
      if (sel4 !== es) begin failures++; $display("FAIL dut4_sel[%0d] got=%h exp=%h", i, sel4, es); end
      checks++;
      if (char4 !== 8'h06) begin failures++; $display("FAIL dut4_char[%0d] got=%h exp=06", i, char4); end
      checks++;
      if (frame4 !== (i == 8)) begin failures++; $display("FAIL dut4_frame[%0d] got=%b", i, frame4); end
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] es;
    int k;
    wait_frame();
    repeat (6) @(negedge clk);
    data_i = 32'hDEADBEEF;
    dp_i   = 8'hFF;
    load_i = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
    @(negedge clk);
    checks++;
    if (tube_sel_o === 8'hFF) begin failures++; $display("FAIL pre_reset_sel got=%h exp=active", tube_sel_o); end
    rstn = 1'b0;
    #1;
    checks++;
    if (tube_sel_o !== 8'hFF || tube_char_o !== 8'hFF || frame_o !== 1'b0) begin
      failures++; $display("FAIL async_reset got=%h/%h/%b exp=ff/ff/0", tube_sel_o, tube_char_o, frame_o);
    end
    @(negedge clk);
    rstn = 1'b1;
    for (int f = 0; f < 2; f++) begin
      capture_frame(1'b0, -1, 32'h0, 8'h00);
      for (int i = 1; i <= 32; i++) begin
        k  = (i - 1) / 4;
        es = ~(8'b1 << k);
        checks++;
        if (cap_sel[i] !== es) begin failures++; $display("FAIL rst_sel[%0d.%0d] got=%h exp=%h", f, i, cap_sel[i], es); end
        checks++;
        if (cap_char[i] !== 8'hC0) begin failures++; $display("FAIL rst_char[%0d.%0d] got=%h exp=c0", f, i, cap_char[i]); end
        checks++;
        if (cap_frame[i] !== (i == 32)) begin failures++; $display("FAIL rst_frame[%0d.%0d] got=%b", f, i, cap_frame[i]); end
      end
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rstn       = 1'b0;
    data_i     = 32'h0;
    dp_i       = 8'h00;
    load_i     = 1'b0;
    blank_lz_i = 1'b0;
    en_i       = 1'b1;
    data4      = 16'h0;
    dp4        = 4'h0;
    load4      = 1'b0;
    blank4     = 1'b0;
    en4        = 1'b1;

    test_reset();
    test_basic();
    test_midframe_load();
    test_wrap_load();
    test_blanking();
    test_enable();
    test_four_digit();
    test_reset_midframe();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Parametrised multiplexed seven-segment display controller. It is the next generation of the board-level 8-digit tube driver that shows CPU, register and memory data on the FPGA top.
- Generalised over digit count, scan rate and output polarity. Adds leading-zero blanking, per-digit decimal points, a global enable, and tear-free double-buffered loading with a frame-boundary update and frame strobe.
- Sits between the debug display mux and the board tube pins.

Parameters:
- NUM_DIGITS, 8: number of digits scanned; valid range 1..16.
- SCAN_DIV, 50000: clk cycles each digit stays selected; must be >= 2.
- SEG_ACTIVE_LOW, 1: 1 = segment outputs driven low to light.
- SEL_ACTIVE_LOW, 1: 1 = digit select driven low to enable.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- data_i  in  4*NUM_DIGITS  hex nibbles; nibble k drives digit k; digit 0 is rightmost/LSB.
- dp_i  in  NUM_DIGITS  decimal-point request per digit.
- load_i  in  1  request to capture data_i/dp_i into the pending buffer.
- blank_lz_i  in  1  enable leading-zero blanking.
- en_i  in  1  display enable.
- tube_sel_o  out  NUM_DIGITS  one-hot digit select (polarity per SEL_ACTIVE_LOW).
- tube_char_o  out  8  segments; bit7 = dp, bits6..0 = g..a (polarity per SEG_ACTIVE_LOW).
- frame_o  out  1  one-cycle pulse when the scan wraps from the last digit to digit 0.

Behaviour:
- Reset (rstn low, asynchronous):
  - div counter, digit index, shown buffer, pending buffer and pending flag all 0.
  - tube_sel_o and tube_char_o at their inactive level (all digits off, all segments off).
  - frame_o = 0.
- Div counter counts 0..SCAN_DIV-1. At terminal count it returns to 0 and the digit index advances. Index wraps NUM_DIGITS-1 -> 0.
- frame_o = 1 for exactly the cycle in which the index wraps to 0. For NUM_DIGITS = 1 it pulses every SCAN_DIV cycles.
- Outputs are registered:
  - tube_sel_o/tube_char_o reflect the new digit index one clk after the index changes.
  - Each digit is lit for exactly SCAN_DIV cycles.
- Double buffering:
  - load_i high in any cycle copies data_i/dp_i into the pending buffer and sets the pending flag. The last load before the wrap wins.
  - At wrap, if pending is set: pending buffer -> shown buffer, flag cleared.
  - load_i asserted in the wrap cycle itself: the data on data_i that cycle goes straight to the shown buffer and the flag is left clear.
  - Shown data never changes mid-frame.
- Decode: standard hex glyphs 0-9, A, b, C, d, E, F. Active-high g..a codes:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
  - Inverted when SEG_ACTIVE_LOW = 1. bit7 = dp of the shown digit, inverted likewise.
- Leading-zero blanking (blank_lz_i = 1):
  - A digit k > 0 is blanked (segments g..a off) when it and every higher digit are 0.
  - Digit 0 is never blanked, so all zeros shows "0".
  - dp is unaffected by blanking.
  - Blanking is evaluated on the shown buffer.
- en_i = 0: tube_sel_o is all inactive from the next clk. Counters, buffering and frame_o keep running, and display resumes at the current index when en_i returns to 1.
- blank_lz_i and en_i are sampled every cycle and are not buffered.
- Reset mid-frame: immediate return to the reset state. Pending data is discarded.

Test Plan:
- NUM_DIGITS=8, SCAN_DIV=4, active-low both, load data_i=0x12345678 and wait one frame:
  - digit 0 selected with tube_sel_o=8'hFE and tube_char_o=~8'h7F (glyph "8").
  - digit 7 selected with tube_sel_o=8'h7F and tube_char_o=~8'h06.
  - each digit held 4 cycles; frame_o every 32 cycles.
- Load 0x0000ABCD mid-frame: the current frame still shows the old value; the new value appears starting with digit 0 one clk after the next frame_o. Repeat with load_i coincident with the wrap cycle: the new value shows in that same new frame.
- blank_lz_i=1, data 0x000000F0:
  - digits 7..2 show segments ~0x00.
  - digit 1 shows ~0x71, digit 0 shows ~0x3F.
  - data 0: only digit 0 lit, showing "0".
- dp_i=8'h04 with blanking on and data 0: digit 2 outputs ~8'h80 (dp only).
- Toggle en_i low for 10 cycles: tube_sel_o=8'hFF throughout, frame_o period unchanged. Assert rstn low mid-frame: outputs inactive immediately; after release, scanning restarts at digit 0 with the shown value 0.
- NUM_DIGITS=4, SCAN_DIV=2, SEG_ACTIVE_LOW=0, SEL_ACTIVE_LOW=0: tube_sel_o cycles 1,2,4,8 with 2 cycles each; glyph "1" outputs 8'h06.
